// File: rtl/vga_sync.sv
`default_nettype none
// ============================================================================
// Module   : vga_sync
// Purpose  : VGA scan-timing generator with registered syncs and frame strobes.
// Revision : 1.0 - initial release
// ============================================================================
module vga_sync #(
    parameter int DIV     = 2,
    parameter int H_DISP  = 640,
    parameter int H_FP    = 16,
    parameter int H_SYNC  = 96,
    parameter int H_BP    = 48,
    parameter int V_DISP  = 480,
    parameter int V_FP    = 10,
    parameter int V_SYNC  = 2,
    parameter int V_BP    = 33,
    parameter int UPD_DLY = 16
) (
    input  logic       clk,
    input  logic       rst,
    output logic       pixel_tick,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    output logic       video_on,
    output logic       hsync,
    output logic       vsync,
    output logic       update_allow_frist_pluse,
    output logic       update_allow_first_pluse_16dly
);

    localparam int         c_h_total  = H_DISP + H_FP + H_SYNC + H_BP;
    localparam int         c_v_total  = V_DISP + V_FP + V_SYNC + V_BP;
    localparam logic [3:0] c_div_max  = 4'(DIV - 1);
    localparam logic [9:0] c_h_max    = 10'(c_h_total - 1);
    localparam logic [9:0] c_v_max    = 10'(c_v_total - 1);
    localparam logic [9:0] c_h_disp   = 10'(H_DISP);
    localparam logic [9:0] c_v_disp   = 10'(V_DISP);
    localparam logic [9:0] c_hs_first = 10'(H_DISP + H_FP);
    localparam logic [9:0] c_hs_last  = 10'(H_DISP + H_FP + H_SYNC - 1);
    localparam logic [9:0] c_vs_first = 10'(V_DISP + V_FP);
    localparam logic [9:0] c_vs_last  = 10'(V_DISP + V_FP + V_SYNC - 1);

    logic [3:0]         r_div;
    logic               r_tick;
    logic [9:0]         r_x;
    logic [9:0]         r_y;
    logic               r_hsync;
    logic               r_vsync;
    logic               r_strobe;
    logic [UPD_DLY-1:0] r_dly;
    logic [9:0]         w_x_next;
    logic [9:0]         w_y_next;

    always_comb begin
        w_x_next = r_x;
        w_y_next = r_y;
        if (r_tick) begin
            if (r_x == c_h_max) begin
                w_x_next = '0;
                w_y_next = (r_y == c_v_max) ? '0 : r_y + 10'd1;
            end else begin
                w_x_next = r_x + 10'd1;
            end
        end
    end

    // Syncs and the frame strobe come from the next-state counters so they
    // line up with pixel_x/pixel_y on the same clk.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_div    <= '0;
            r_tick   <= 1'b0;
            r_x      <= '0;
            r_y      <= '0;
            r_hsync  <= 1'b1;
            r_vsync  <= 1'b1;
            r_strobe <= 1'b0;
        end else begin
            r_div    <= (r_div == c_div_max) ? '0 : r_div + 4'd1;
            r_tick   <= (r_div == c_div_max);
            r_x      <= w_x_next;
            r_y      <= w_y_next;
            r_hsync  <= !((w_x_next >= c_hs_first) && (w_x_next <= c_hs_last));
            r_vsync  <= !((w_y_next >= c_vs_first) && (w_y_next <= c_vs_last));
            r_strobe <= r_tick && (w_x_next == '0) && (w_y_next == c_v_disp);
        end
    end

    generate
        if (UPD_DLY == 1) begin : g_dly_single
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_dly <= '0;
                end else begin
                    r_dly <= r_strobe;
                end
            end
        end else begin : g_dly_shift
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_dly <= '0;
                end else begin
                    r_dly <= {r_dly[UPD_DLY-2:0], r_strobe};
                end
            end
        end
    endgenerate

    assign pixel_tick                     = r_tick;
    assign pixel_x                        = r_x;
    assign pixel_y                        = r_y;
    assign video_on                       = (r_x < c_h_disp) && (r_y < c_v_disp);
    assign hsync                          = r_hsync;
    assign vsync                          = r_vsync;
    assign update_allow_frist_pluse       = r_strobe;
    assign update_allow_first_pluse_16dly = r_dly[UPD_DLY-1];

endmodule
`default_nettype wire

// File: tb/tb_vga_sync.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_sync
// Purpose  : Directed self-checking bench for vga_sync (full-size and reduced timings).
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_sync;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Full-size instance (default parameters)
    logic       rst_d;
    logic       d_tick, d_von, d_hs, d_vs, d_st, d_dly;
    logic [9:0] d_x, d_y;

    vga_sync u_def (
        .clk                            (clk),
        .rst                            (rst_d),
        .pixel_tick                     (d_tick),
        .pixel_x                        (d_x),
        .pixel_y                        (d_y),
        .video_on                       (d_von),
        .hsync                          (d_hs),
        .vsync                          (d_vs),
        .update_allow_frist_pluse       (d_st),
        .update_allow_first_pluse_16dly (d_dly)
    );

    // Reduced timing: H 8/2/3/3 (16 total), V 6/2/2/2 (12 total); [0] DIV=2, [1] DIV=1
    logic       m_rst  [2];
    logic       m_tick [2];
    logic       m_von  [2];
    logic       m_hs   [2];
    logic       m_vs   [2];
    logic       m_st   [2];
    logic       m_dly  [2];
    logic [9:0] m_x    [2];
    logic [9:0] m_y    [2];

    vga_sync #(
        .DIV(2), .H_DISP(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_DISP(6), .V_FP(2), .V_SYNC(2), .V_BP(2), .UPD_DLY(16)
    ) u_small (
        .clk                            (clk),
        .rst                            (m_rst[0]),
        .pixel_tick                     (m_tick[0]),
        .pixel_x                        (m_x[0]),
        .pixel_y                        (m_y[0]),
        .video_on                       (m_von[0]),
        .hsync                          (m_hs[0]),
        .vsync                          (m_vs[0]),
        .update_allow_frist_pluse       (m_st[0]),
        .update_allow_first_pluse_16dly (m_dly[0])
    );

    vga_sync #(
        .DIV(1), .H_DISP(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_DISP(6), .V_FP(2), .V_SYNC(2), .V_BP(2), .UPD_DLY(16)
    ) u_div1 (
        .clk                            (clk),
        .rst                            (m_rst[1]),
        .pixel_tick                     (m_tick[1]),
        .pixel_x                        (m_x[1]),
        .pixel_y                        (m_y[1]),
        .video_on                       (m_von[1]),
        .hsync                          (m_hs[1]),
        .vsync                          (m_vs[1]),
        .update_allow_frist_pluse       (m_st[1]),
        .update_allow_first_pluse_16dly (m_dly[1])
    );

    // Cycle-by-cycle reference model for the two reduced instances
    int         rel [2];
    int         last_st [2];
    int         n_st [2], st_first [2], st_second [2], st_last [2];
    int         n_dly [2], dly_first [2], dly_last [2];
    logic [9:0] px [2], py [2];
    logic       ptick [2];

    initial begin
        for (int k = 0; k < 2; k++) begin
            n_st[k] = 0; st_first[k] = 0; st_second[k] = 0; st_last[k] = 0;
            n_dly[k] = 0; dly_first[k] = 0; dly_last[k] = 0;
        end
    end

    always @(posedge clk) begin
        int         n, dv;
        logic [9:0] ex, ey;
        logic       et, es, ed, eh, ev, eo;
        #1;
        for (int k = 0; k < 2; k++) begin
            if (!m_rst[k]) begin
                rel[k]     = cyc;
                last_st[k] = -1000;
                px[k]      = '0;
                py[k]      = '0;
                ptick[k]   = 1'b0;
            end else begin
                dv = (k == 0) ? 2 : 1;
                n  = cyc - rel[k];
                et = (n >= dv) && (n % dv == 0);
                ex = px[k];
                ey = py[k];
                if (ptick[k]) begin
                    if (px[k] == 10'd15) begin
                        ex = '0;
                        ey = (py[k] == 10'd11) ? 10'd0 : py[k] + 10'd1;
                    end else begin
                        ex = px[k] + 10'd1;
                    end
                end
                es = ptick[k] && (ex == 10'd0) && (ey == 10'd6);
                ed = (cyc - last_st[k] == 16);
                eh = !(ex >= 10'd10 && ex <= 10'd12);
                ev = !(ey >= 10'd8 && ey <= 10'd9);
                eo = (ex < 10'd8) && (ey < 10'd6);
                check($sformatf("m%0d_tick", k), 32'(m_tick[k]), 32'(et));
                check($sformatf("m%0d_x", k), 32'(m_x[k]), 32'(ex));
                check($sformatf("m%0d_y", k), 32'(m_y[k]), 32'(ey));
                check($sformatf("m%0d_strobe", k), 32'(m_st[k]), 32'(es));
                check($sformatf("m%0d_dly", k), 32'(m_dly[k]), 32'(ed));
                check($sformatf("m%0d_hsync", k), 32'(m_hs[k]), 32'(eh));
                check($sformatf("m%0d_vsync", k), 32'(m_vs[k]), 32'(ev));
                check($sformatf("m%0d_video_on", k), 32'(m_von[k]), 32'(eo));
                if (m_st[k]) begin
                    n_st[k]++;
                    if (n_st[k] == 1) st_first[k] = cyc;
                    if (n_st[k] == 2) st_second[k] = cyc;
                    st_last[k] = cyc;
                    last_st[k] = cyc;
                end
                if (m_dly[k]) begin
                    n_dly[k]++;
                    if (n_dly[k] == 1) dly_first[k] = cyc;
                    dly_last[k] = cyc;
                end
                px[k]    = m_x[k];
                py[k]    = m_y[k];
                ptick[k] = m_tick[k];
            end
        end
    end

    // Event capture for the full-size instance
    int         d_tick_first = 0, d_wrap0 = 0, d_wrap1 = 0, d_nwrap = 0, d_fall = 0, d_rise = 0;
    logic [9:0] d_fall_x = '0, d_y_wrap0 = '0, dpx = '0;
    logic       dphs = 1'b1, d_von_fall = 1'b1;

    always @(posedge clk) begin
        #1;
        if (rst_d) begin
            if (d_tick && d_tick_first == 0) d_tick_first = cyc;
            if (dpx == 10'd799 && d_x == 10'd0) begin
                if (d_nwrap == 0) begin
                    d_wrap0   = cyc;
                    d_y_wrap0 = d_y;
                end
                if (d_nwrap == 1) d_wrap1 = cyc;
                d_nwrap++;
            end
            if (dphs && !d_hs && d_fall == 0) begin
                d_fall     = cyc;
                d_fall_x   = d_x;
                d_von_fall = d_von;
            end
            if (!dphs && d_hs && d_rise == 0) d_rise = cyc;
        end
        dpx  = d_x;
        dphs = d_hs;
    end

    int rel0, rel2, cnt0;
    bit found;

    initial begin
        rst_d    = 1'b0;
        m_rst[0] = 1'b0;
        m_rst[1] = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("rst_x", 32'(d_x), 32'd0);
        check("rst_y", 32'(d_y), 32'd0);
        check("rst_hsync", 32'(d_hs), 32'd1);
        check("rst_vsync", 32'(d_vs), 32'd1);
        check("rst_strobe", 32'(d_st), 32'd0);
        check("rst_dly", 32'(d_dly), 32'd0);
        check("rst_video_on", 32'(d_von), 32'd1);
        check("rst_tick", 32'(d_tick), 32'd0);
        check("rst_tick_div1", 32'(m_tick[1]), 32'd0);

        @(negedge clk);
        rst_d    = 1'b1;
        m_rst[0] = 1'b1;
        m_rst[1] = 1'b1;
        rel0     = cyc;
        repeat (3400) @(posedge clk);
        #1;

        // Full-size line timing, DIV=2
        check("def_first_tick", d_tick_first - rel0, 2);
        check("def_first_wrap", d_wrap0 - rel0, 1601);
        check("def_y_after_wrap", 32'(d_y_wrap0), 32'd1);
        check("def_line_period", d_wrap1 - d_wrap0, 1600);
        check("def_hsync_fall", d_fall - rel0, 1313);
        check("def_hsync_fall_x", 32'(d_fall_x), 32'd656);
        check("def_hsync_width", d_rise - d_fall, 192);
        check("def_video_on_blank", 32'(d_von_fall), 32'd0);

        // Reduced frame timing and strobes
        check("s_first_strobe", st_first[0] - rel0, 193);
        check("s_frame_period", st_second[0] - st_first[0], 384);
        check("s_dly_offset", dly_first[0] - st_first[0], 16);
        check("s_strobe_count", n_st[0], 9);
        check("s_dly_count", n_dly[0], 9);
        check("d1_first_strobe", st_first[1] - rel0, 97);
        check("d1_frame_period", st_second[1] - st_first[1], 192);
        check("d1_dly_offset", dly_first[1] - st_first[1], 16);
        check("d1_strobe_count", n_st[1], 18);
        check("d1_dly_count", n_dly[1], 18);

        // Mid-frame reset drops the in-flight delayed strobe
        found = 1'b0;
        for (int i = 0; i < 500 && !found; i++) begin
            @(posedge clk);
            #1;
            if (m_st[0]) found = 1'b1;
        end
        check("mid_strobe_seen", 32'(found), 32'd1);
        cnt0 = n_dly[0];
        repeat (5) @(posedge clk);
        @(negedge clk);
        m_rst[0] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("mid_rst_x", 32'(m_x[0]), 32'd0);
        check("mid_rst_y", 32'(m_y[0]), 32'd0);
        check("mid_rst_dly", 32'(m_dly[0]), 32'd0);
        check("mid_rst_hsync", 32'(m_hs[0]), 32'd1);
        @(negedge clk);
        m_rst[0] = 1'b1;
        rel2     = cyc;
        repeat (220) @(posedge clk);
        #1;
        check("mid_dly_pulses", n_dly[0] - cnt0, 1);
        check("mid_restart_strobe", st_last[0] - rel2, 193);
        check("mid_restart_dly", dly_last[0] - rel2, 209);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
